n_slot_break_dvr: RTL and testbench

N_SLOT_BREAK_DVR -- requirements
Module: n_slot_break_dvr

---
 rtl/n_slot_break_dvr_pkg.sv | 19 +
 rtl/n_slot_break_dvr_dataless.sv | 66 ++++++
 rtl/n_slot_break_dvr.sv | 66 ++++++
 tb/tb_n_slot_break_dvr.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/n_slot_break_dvr_pkg.sv
// Shared handshake package for the slot-break driver: width helpers used by
// the control sub-module and the top level.
package n_slot_break_dvr_pkg;

    // Pointer width for a circular store of `slots` entries, never below 1 bit.
    function automatic int ptr_width(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    // Width able to hold an occupancy count from 0 up to `slots` inclusive.
    function automatic int cnt_width(input int slots);
        return $clog2(slots + 1);
    endfunction

    localparam int DEFAULT_SLOTS = 2;
    localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_SLOTS);
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_SLOTS);

endpackage

// File: rtl/n_slot_break_dvr_dataless.sv
// Control half of the slot-break driver: pointers, occupancy count, and
// valid/ready decoded purely from registered state.
module n_slot_break_dvr_dataless
    import n_slot_break_dvr_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    localparam int PTR_W = ptr_width(NUM_SLOTS),
    localparam int CNT_W = cnt_width(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic             outs_valid,
    input  logic             outs_ready,
    output logic             accept,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    logic             release_hd;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Both flags come from the count register only, so no input reaches them.
    assign outs_valid = (count != '0);
    assign ins_ready  = (count != CNT_W'(NUM_SLOTS));
    assign accept     = ins_valid & ins_ready;
    assign release_hd = outs_valid & outs_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (accept)
            wr_ptr_nxt = ptr_inc(wr_ptr);
        if (release_hd)
            rd_ptr_nxt = ptr_inc(rd_ptr);
        unique case ({accept, release_hd})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

endmodule

// File: rtl/n_slot_break_dvr.sv
// N-slot fully registered handshake buffer (data, valid and ready all broken).
// Optional occupancy output enabled by defining N_SLOT_BREAK_DVR_OCC_EN.
module n_slot_break_dvr
    import n_slot_break_dvr_pkg::*;
#(
    parameter int DATA_TYPE = 32,
    parameter int NUM_SLOTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
`ifdef N_SLOT_BREAK_DVR_OCC_EN
    ,
    output logic [cnt_width(NUM_SLOTS)-1:0] occupancy
`endif
);

    localparam int PTR_W = ptr_width(NUM_SLOTS);
    localparam int CNT_W = cnt_width(NUM_SLOTS);

    logic                 accept;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [DATA_TYPE-1:0] store [NUM_SLOTS];

    n_slot_break_dvr_dataless #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .accept     (accept),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        // NOTE: the store is deliberately cleared on reset so outs reads 0 afterwards; this forces flops rather than RAM.
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                store[i] <= '0;
        end else if (accept) begin
            store[wr_ptr] <= ins;
        end
    end

    assign outs = store[rd_ptr];

`ifdef N_SLOT_BREAK_DVR_OCC_EN
    assign occupancy = count;
`else
    logic unused_count;
    assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_n_slot_break_dvr.sv
// Self-checking bench: three buffer depths (2, 4, 1) driven together and
// compared every cycle against a queue-based reference model.
module tb_n_slot_break_dvr;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins        [NI];
    logic        ins_valid  [NI];
    logic        ins_ready  [NI];
    logic [31:0] outs       [NI];
    logic        outs_valid [NI];
    logic        outs_ready [NI];

    int          cap [NI] = '{2, 4, 1};
    logic [31:0] mq  [NI][$];
    bit          acc [NI];
    bit          rel [NI];
    int          acc_cnt [NI];
    int          rel_cnt [NI];
    int          n_checks = 0;
    int          n_errors = 0;

`ifdef N_SLOT_BREAK_DVR_OCC_EN
    logic [1:0] occ0;
    logic [2:0] occ1;
    logic [0:0] occ2;
`endif

    always #5 clk = ~clk;

    n_slot_break_dvr #(.DATA_TYPE(32), .NUM_SLOTS(2)) dut0 (
        .clk(clk), .rst(rst), .ins(ins[0]), .ins_valid(ins_valid[0]), .ins_ready(ins_ready[0]),
        .outs(outs[0]), .outs_valid(outs_valid[0]), .outs_ready(outs_ready[0])
`ifdef N_SLOT_BREAK_DVR_OCC_EN
        , .occupancy(occ0)
`endif
    );

    n_slot_break_dvr #(.DATA_TYPE(32), .NUM_SLOTS(4)) dut1 (
        .clk(clk), .rst(rst), .ins(ins[1]), .ins_valid(ins_valid[1]), .ins_ready(ins_ready[1]),
        .outs(outs[1]), .outs_valid(outs_valid[1]), .outs_ready(outs_ready[1])
`ifdef N_SLOT_BREAK_DVR_OCC_EN
        , .occupancy(occ1)
`endif
    );

    n_slot_break_dvr #(.DATA_TYPE(32), .NUM_SLOTS(1)) dut2 (
        .clk(clk), .rst(rst), .ins(ins[2]), .ins_valid(ins_valid[2]), .ins_ready(ins_ready[2]),
        .outs(outs[2]), .outs_valid(outs_valid[2]), .outs_ready(outs_ready[2])
`ifdef N_SLOT_BREAK_DVR_OCC_EN
        , .occupancy(occ2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all instances against the model at the falling edge, then
    // apply the handshakes the model predicts at the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            int sz;
            sz = mq[i].size();
            check($sformatf("outs_valid[%0d]", i), 32'(outs_valid[i]), 32'(sz != 0));
            check($sformatf("ins_ready[%0d]", i), 32'(ins_ready[i]), 32'(sz < cap[i]));
            if (sz != 0)
                check($sformatf("outs[%0d]", i), outs[i], mq[i][0]);
            acc[i] = !rst && ins_valid[i] && (sz < cap[i]);
            rel[i] = !rst && outs_ready[i] && (sz != 0);
        end
`ifdef N_SLOT_BREAK_DVR_OCC_EN
        check("occupancy[0]", 32'(occ0), 32'(mq[0].size()));
        check("occupancy[1]", 32'(occ1), 32'(mq[1].size()));
        check("occupancy[2]", 32'(occ2), 32'(mq[2].size()));
`endif
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                mq[i].delete();
            end else begin
                if (rel[i]) begin
                    void'(mq[i].pop_front());
                    rel_cnt[i]++;
                end
                if (acc[i]) begin
                    mq[i].push_back(ins[i]);
                    acc_cnt[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            ins[i]        = '0;
            ins_valid[i]  = 1'b0;
            outs_ready[i] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int base;
        for (int i = 0; i < NI; i++) begin
            acc_cnt[i] = 0;
            rel_cnt[i] = 0;
        end
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state: empty, ready, store reads zero.
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_outs_valid[%0d]", i), 32'(outs_valid[i]), 32'd0);
            check($sformatf("rst_ins_ready[%0d]", i), 32'(ins_ready[i]), 32'd1);
            check($sformatf("rst_outs[%0d]", i), outs[i], 32'd0);
        end

        // Single beat, latency one cycle, then empty.
        ins[0] = 32'hA5; ins_valid[0] = 1'b1; outs_ready[0] = 1'b1;
        tick();
        ins_valid[0] = 1'b0;
        check("single_valid", 32'(outs_valid[0]), 32'd1);
        check("single_data", outs[0], 32'hA5);
        tick();
        check("single_empty", 32'(outs_valid[0]), 32'd0);

        // Depth 4: fill while stalled, fifth beat held, then drain in order.
        outs_ready[1] = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            ins[1] = 32'(v); ins_valid[1] = 1'b1;
            tick();
        end
        check("full_ins_ready", 32'(ins_ready[1]), 32'd0);
        check("full_accepts", 32'(acc_cnt[1]), 32'd4);
        base = rel_cnt[1];
        outs_ready[1] = 1'b1;
        tick();
        check("full_release_no_accept", 32'(acc_cnt[1]), 32'd4);
        check("ready_after_release", 32'(ins_ready[1]), 32'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (acc[1]) ins_valid[1] = 1'b0;
        end
        check("drain_count", 32'(rel_cnt[1] - base), 32'd5);

        // Depth 2: 100 back-to-back beats, no bubbles after the first.
        sent = 0;
        base = rel_cnt[0];
        outs_ready[0] = 1'b1;
        for (int c = 0; c < 101; c++) begin
            ins[0] = 32'(1000 + sent);
            ins_valid[0] = (sent < 100);
            tick();
            if (acc[0]) sent++;
        end
        ins_valid[0] = 1'b0;
        check("stream_sent", 32'(sent), 32'd100);
        check("stream_released", 32'(rel_cnt[0] - base), 32'd100);

        // Depth 1: continuous traffic gives alternating ready and half rate.
        base = acc_cnt[2];
        outs_ready[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("alt_ready_%0d", k), 32'(ins_ready[2]), 32'(k % 2 == 0));
            ins[2] = 32'(500 + k); ins_valid[2] = 1'b1;
            tick();
        end
        ins_valid[2] = 1'b0;
        check("half_rate", 32'(acc_cnt[2] - base), 32'd10);
        tick();

        // Reset with three entries buffered and handshakes pending.
        outs_ready[1] = 1'b0;
        for (int v = 0; v < 3; v++) begin
            ins[1] = 32'(70 + v); ins_valid[1] = 1'b1;
            tick();
        end
        check("pre_rst_count", 32'(mq[1].size()), 32'd3);
        outs_ready[1] = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ins_valid[1] = 1'b0;
        check("mid_rst_valid", 32'(outs_valid[1]), 32'd0);
        check("mid_rst_ready", 32'(ins_ready[1]), 32'd1);
`ifdef N_SLOT_BREAK_DVR_OCC_EN
        check("mid_rst_occ", 32'(occ1), 32'd0);
`endif
        base = rel_cnt[1];
        for (int c = 0; c < 4; c++) tick();
        check("no_stale", 32'(rel_cnt[1] - base), 32'd0);

        // Random traffic on all depths with rare resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++) begin
                ins[i]        = $urandom;
                ins_valid[i]  = ($urandom_range(0, 9) < 6);
                outs_ready[i] = ($urandom_range(0, 9) < 6);
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle_all();
        for (int i = 0; i < NI; i++) outs_ready[i] = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        for (int i = 0; i < NI; i++)
            check($sformatf("final_empty[%0d]", i), 32'(outs_valid[i]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
